// File: rtl/dmem_defs.sv
`default_nettype none
// ============================================================================
// dmem_defs : shared encodings for the MEM-stage data-memory access path
// Revision  : 1.0 - initial release
// ============================================================================
package dmem_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  localparam logic [1:0] c_SZ_B = 2'b00;
  localparam logic [1:0] c_SZ_H = 2'b01;
  localparam logic [1:0] c_SZ_W = 2'b10;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// dmem_lane_align : misalign check, store lane steering, load extract/extend
// Revision        : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_defs::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_load,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_rd_addr_lo,
  input  logic [2:0]  i_rd_funct3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_ext
);

  logic [31:0] w_shifted;

  always_comb begin
    o_misalign = 1'b0;
    o_be       = 4'b1111;
    o_wdata    = i_st_data;
    if (i_is_load) begin
      case (i_ld_funct3)
        c_F3_LB, c_F3_LBU: o_misalign = 1'b0;
        c_F3_LH, c_F3_LHU: o_misalign = i_addr_lo[0];
        c_F3_LW:           o_misalign = |i_addr_lo;
        default:           o_misalign = |i_addr_lo;
      endcase
    end else begin
      case (i_st_size)
        c_SZ_B: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_st_data[7:0]}};
        end
        c_SZ_H: begin
          o_be       = 4'b0011 << i_addr_lo;
          o_wdata    = {2{i_st_data[15:0]}};
          o_misalign = i_addr_lo[0];
        end
        c_SZ_W:  o_misalign = |i_addr_lo;
        default: o_misalign = |i_addr_lo;
      endcase
    end
  end

  // Load side uses the offset/funct3 captured at request time.
  assign w_shifted = i_rdata >> {i_rd_addr_lo, 3'b000};

  always_comb begin
    o_load_ext = w_shifted;
    case (i_rd_funct3)
      c_F3_LB:  o_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      c_F3_LH:  o_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      c_F3_LBU: o_load_ext = {24'd0, w_shifted[7:0]};
      c_F3_LHU: o_load_ext = {16'd0, w_shifted[15:0]};
      default:  o_load_ext = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_access_ctrl : MEM-stage data-memory request/ack sequencer with stall
//                    Optional bus timeout: define DMEM_ACCESS_TIMEOUT_EN
// Revision         : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
  import dmem_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_REG_DATA2,
  input  logic [3:0]  MEM_DATA_MEM_READ,
  input  logic [2:0]  MEM_DATA_MEM_WRITE,
  output logic        STALL,
  output logic [31:0] LOAD_DATA,
  output logic        MISALIGN,
  output logic        BUS_ERR,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK
);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_load;
  logic        w_access;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;

  logic        r_is_load;
  logic [2:0]  r_ld_funct3;
  logic [1:0]  r_ld_lo;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_be;
  logic [31:0] r_load_data;
  logic        r_misalign;

  // A load takes priority when both enables are set.
  assign w_load   = MEM_DATA_MEM_READ[3];
  assign w_access = w_load | MEM_DATA_MEM_WRITE[2];

  dmem_lane_align u_lane_align (
    .i_addr_lo    (MEM_ALU_OUT[1:0]),
    .i_is_load    (w_load),
    .i_ld_funct3  (MEM_DATA_MEM_READ[2:0]),
    .i_st_size    (MEM_DATA_MEM_WRITE[1:0]),
    .i_st_data    (MEM_REG_DATA2),
    .o_misalign   (w_misalign),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_rd_addr_lo (r_ld_lo),
    .i_rd_funct3  (r_ld_funct3),
    .i_rdata      (DMEM_RDATA),
    .o_load_ext   (w_load_ext)
  );

`ifdef DMEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait_cnt;
  logic       r_bus_err;

  assign w_timeout = (r_state == WAIT) && (r_wait_cnt == c_TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wait_cnt <= 8'd0;
      r_bus_err  <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 8'd1 : 8'd0;
      r_bus_err  <= w_timeout && !DMEM_ACK;
    end
  end

  assign BUS_ERR = r_bus_err;
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign BUS_ERR          = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    STALL        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          STALL        = 1'b1;
          w_next_state = w_misalign ? DONE : WAIT;
        end
      end
      WAIT: begin
        STALL = 1'b1;
        if (DMEM_ACK || w_timeout) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_is_load    <= 1'b0;
      r_ld_funct3  <= 3'd0;
      r_ld_lo      <= 2'd0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_be    <= 4'd0;
      r_load_data  <= 32'd0;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access && w_misalign) begin
            r_misalign <= 1'b1;
          end else if (w_access) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= ~w_load;
            r_dmem_addr  <= {MEM_ALU_OUT[31:2], 2'b00};
            r_dmem_wdata <= w_wdata;
            r_dmem_be    <= w_be;
            r_is_load    <= w_load;
            r_ld_funct3  <= MEM_DATA_MEM_READ[2:0];
            r_ld_lo      <= MEM_ALU_OUT[1:0];
          end
        end
        WAIT: begin
          // An ACK coinciding with timeout expiry completes normally.
          if (DMEM_ACK) begin
            r_dmem_req <= 1'b0;
            if (r_is_load) r_load_data <= w_load_ext;
          end else if (w_timeout) begin
            r_dmem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign LOAD_DATA  = r_load_data;
  assign MISALIGN   = r_misalign;
  assign DMEM_REQ   = r_dmem_req;
  assign DMEM_WE    = r_dmem_we;
  assign DMEM_ADDR  = r_dmem_addr;
  assign DMEM_WDATA = r_dmem_wdata;
  assign DMEM_BE    = r_dmem_be;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_access_ctrl : scoreboard bench for dmem_access_ctrl
// Revision            : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] MEM_ALU_OUT;
  logic [31:0] MEM_REG_DATA2;
  logic [3:0]  MEM_DATA_MEM_READ;
  logic [2:0]  MEM_DATA_MEM_WRITE;
  logic        STALL;
  logic [31:0] LOAD_DATA;
  logic        MISALIGN;
  logic        BUS_ERR;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
  } req_t;

  req_t        r_exp_req[$];
  logic [31:0] r_exp_ld[$];
  logic [31:0] r_model_ld = 32'd0;
  logic        r_prev_req = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 CLK = ~CLK;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .MEM_ALU_OUT        (MEM_ALU_OUT),
    .MEM_REG_DATA2      (MEM_REG_DATA2),
    .MEM_DATA_MEM_READ  (MEM_DATA_MEM_READ),
    .MEM_DATA_MEM_WRITE (MEM_DATA_MEM_WRITE),
    .STALL              (STALL),
    .LOAD_DATA          (LOAD_DATA),
    .MISALIGN           (MISALIGN),
    .BUS_ERR            (BUS_ERR),
    .DMEM_REQ           (DMEM_REQ),
    .DMEM_WE            (DMEM_WE),
    .DMEM_ADDR          (DMEM_ADDR),
    .DMEM_WDATA         (DMEM_WDATA),
    .DMEM_BE            (DMEM_BE),
    .DMEM_RDATA         (DMEM_RDATA),
    .DMEM_ACK           (DMEM_ACK)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Request monitor: every rising DMEM_REQ must match the oldest queued request.
  always @(negedge CLK) begin
    req_t r;
    if (DMEM_REQ && !r_prev_req) begin
      chk("req_q_depth", 32'(r_exp_req.size()), 32'd1);
      if (r_exp_req.size() > 0) begin
        r = r_exp_req.pop_front();
        chk("dmem_addr", DMEM_ADDR, r.addr);
        chk("dmem_we", {31'd0, DMEM_WE}, {31'd0, r.we});
        chk("dmem_be", {28'd0, DMEM_BE}, {28'd0, r.be});
        if (r.chk_wd) chk("dmem_wdata", DMEM_WDATA, r.wdata);
      end
    end
    r_prev_req = DMEM_REQ;
  end

  task automatic drive_idle();
    MEM_DATA_MEM_READ  = 4'd0;
    MEM_DATA_MEM_WRITE = 3'd0;
    MEM_ALU_OUT        = 32'd0;
    MEM_REG_DATA2      = 32'd0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
  task automatic run_access(input logic [3:0] rd, input logic [2:0] wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input int ack_dly, input logic [31:0] rdata,
                            input logic [31:0] xaddr, input logic xwe,
                            input logic [3:0] xbe, input logic [31:0] xwdata,
                            input logic xchk_wd, input logic xld,
                            input logic [31:0] xload);
    req_t r;
    r.addr = xaddr; r.we = xwe; r.be = xbe; r.wdata = xwdata; r.chk_wd = xchk_wd;
    r_exp_req.push_back(r);
    if (xld) r_model_ld = xload;
    r_exp_ld.push_back(r_model_ld);
    MEM_DATA_MEM_READ  = rd;
    MEM_DATA_MEM_WRITE = wr;
    MEM_ALU_OUT        = addr;
    MEM_REG_DATA2      = data;
    @(negedge CLK);
    chk("stall_c0", {31'd0, STALL}, 32'd1);
    for (int c = 1; c <= ack_dly; c++) begin
      @(posedge CLK); #1;
      DMEM_ACK   = (c == ack_dly);
      DMEM_RDATA = (c == ack_dly) ? rdata : 32'h5A5A5A5A;
      @(negedge CLK);
      chk("stall_wait", {31'd0, STALL}, 32'd1);
    end
    @(posedge CLK); #1;
    DMEM_ACK = 1'b0;
    @(negedge CLK);
    chk("stall_done", {31'd0, STALL}, 32'd0);
    chk("req_done", {31'd0, DMEM_REQ}, 32'd0);
    chk("load_data", LOAD_DATA, r_exp_ld.pop_front());
    chk("misalign_ok", {31'd0, MISALIGN}, 32'd0);
    chk("bus_err_ok", {31'd0, BUS_ERR}, 32'd0);
    @(posedge CLK); #1;
    drive_idle();
  endtask

  task automatic run_misalign(input logic [3:0] rd, input logic [2:0] wr,
                              input logic [31:0] addr);
    MEM_DATA_MEM_READ  = rd;
    MEM_DATA_MEM_WRITE = wr;
    MEM_ALU_OUT        = addr;
    MEM_REG_DATA2      = 32'hFFFF_0000;
    @(negedge CLK);
    chk("mis_stall_c0", {31'd0, STALL}, 32'd1);
    chk("mis_req_c0", {31'd0, DMEM_REQ}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mis_pulse", {31'd0, MISALIGN}, 32'd1);
    chk("mis_stall_c1", {31'd0, STALL}, 32'd0);
    chk("mis_req_c1", {31'd0, DMEM_REQ}, 32'd0);
    chk("mis_load_data", LOAD_DATA, r_model_ld);
    @(posedge CLK); #1;
    drive_idle();
    @(negedge CLK);
    chk("mis_pulse_end", {31'd0, MISALIGN}, 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    RESET      = 1'b1;
    DMEM_ACK   = 1'b0;
    DMEM_RDATA = 32'd0;
    drive_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_stall", {31'd0, STALL}, 32'd0);
    chk("rst_req", {31'd0, DMEM_REQ}, 32'd0);
    chk("rst_we", {31'd0, DMEM_WE}, 32'd0);
    chk("rst_addr", DMEM_ADDR, 32'd0);
    chk("rst_wdata", DMEM_WDATA, 32'd0);
    chk("rst_be", {28'd0, DMEM_BE}, 32'd0);
    chk("rst_load_data", LOAD_DATA, 32'd0);
    chk("rst_misalign", {31'd0, MISALIGN}, 32'd0);
    chk("rst_bus_err", {31'd0, BUS_ERR}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    //          rd       wr      addr          data          dly rdata
    run_access(4'b1010, 3'b000, 32'h0000_0100, 32'h0,        1, 32'hDEAD_BEEF,
               32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    run_access(4'b1000, 3'b000, 32'h0000_0103, 32'h0,        1, 32'h80FF_FFFF,
               32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80);
    run_access(4'b1100, 3'b000, 32'h0000_0103, 32'h0,        2, 32'h80FF_FFFF,
               32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
    run_access(4'b0000, 3'b101, 32'h0000_0202, 32'h1234_ABCD, 2, 32'hFFFF_FFFF,
               32'h0000_0200, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b1, 1'b0, 32'h0);
    run_access(4'b1001, 3'b000, 32'h0000_0102, 32'h0,        1, 32'h8001_1234,
               32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001);
    run_access(4'b1101, 3'b000, 32'h0000_0102, 32'h0,        3, 32'h8001_1234,
               32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0000_8001);
    run_access(4'b0000, 3'b100, 32'h0000_0201, 32'hAA55_3377, 1, 32'h0,
               32'h0000_0200, 1'b1, 4'b0010, 32'h7777_7777, 1'b1, 1'b0, 32'h0);
    run_access(4'b0000, 3'b110, 32'h0000_0204, 32'hCAFE_F00D, 3, 32'h0,
               32'h0000_0204, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
    run_access(4'b1010, 3'b110, 32'h0000_0300, 32'h7777_0000, 1, 32'h1122_3344,
               32'h0000_0300, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h1122_3344);

    run_misalign(4'b1010, 3'b000, 32'h0000_0101);
    run_misalign(4'b0000, 3'b101, 32'h0000_0203);
    run_misalign(4'b1011, 3'b000, 32'h0000_0302);

    // Reset while waiting on a slow memory; the late ACK must be ignored.
    begin
      req_t r;
      r.addr = 32'h0000_0400; r.we = 1'b0; r.be = 4'hF; r.wdata = 32'h0; r.chk_wd = 1'b0;
      r_exp_req.push_back(r);
    end
    MEM_DATA_MEM_READ = 4'b1010;
    MEM_ALU_OUT       = 32'h0000_0400;
    @(negedge CLK);
    chk("rw_stall_c0", {31'd0, STALL}, 32'd1);
    repeat (2) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rw_stall_wait", {31'd0, STALL}, 32'd1);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    drive_idle();
    r_model_ld = 32'd0;
    @(negedge CLK);
    chk("rw_req_drop", {31'd0, DMEM_REQ}, 32'd0);
    chk("rw_stall_rel", {31'd0, STALL}, 32'd0);
    @(posedge CLK); #1;
    DMEM_ACK   = 1'b1;
    DMEM_RDATA = 32'h9999_9999;
    @(posedge CLK); #1;
    DMEM_ACK = 1'b0;
    @(negedge CLK);
    chk("rw_late_ack_ld", LOAD_DATA, r_model_ld);
    chk("rw_late_ack_stall", {31'd0, STALL}, 32'd0);
    @(posedge CLK); #1;

    run_access(4'b1010, 3'b000, 32'h0000_0104, 32'h0, 1, 32'h0BAD_F00D,
               32'h0000_0104, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);

`ifdef DMEM_ACCESS_TIMEOUT_EN
    begin
      req_t r;
      logic seen;
      seen = 1'b0;
      r.addr = 32'h0000_0500; r.we = 1'b0; r.be = 4'hF; r.wdata = 32'h0; r.chk_wd = 1'b0;
      r_exp_req.push_back(r);
      MEM_DATA_MEM_READ = 4'b1010;
      MEM_ALU_OUT       = 32'h0000_0500;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge CLK);
        if (BUS_ERR) begin
          seen = 1'b1;
          chk("tmo_stall", {31'd0, STALL}, 32'd0);
          chk("tmo_req", {31'd0, DMEM_REQ}, 32'd0);
          chk("tmo_load_data", LOAD_DATA, r_model_ld);
        end
      end
      chk("tmo_bus_err_seen", {31'd0, seen}, 32'd1);
      @(posedge CLK); #1;
      drive_idle();
      @(negedge CLK);
      chk("tmo_pulse_end", {31'd0, BUS_ERR}, 32'd0);
      @(posedge CLK); #1;
    end
`endif

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("req_q_drain", 32'(r_exp_req.size()), 32'd0);
    chk("ld_q_drain", 32'(r_exp_ld.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access sequencer for the MEM stage of the pipelined CPU. It reads the load/store controls and address/data held by the EX/MEM pipeline register, runs a request/acknowledge transaction with the data memory, and stalls the pipeline until the transaction completes. It also performs byte-lane alignment, generates store byte enables, sign- and zero-extends load data, and flags misaligned accesses.

## Interface
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before a bus-error abort; 1..255. Used only with DMEM_ACCESS_TIMEOUT_EN.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset. Single clock domain.
- MEM_ALU_OUT  in  32  byte address of the access.
- MEM_REG_DATA2  in  32  store data, right-aligned.
- MEM_DATA_MEM_READ  in  4  bit3 = load enable; bits[2:0] = funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- MEM_DATA_MEM_WRITE  in  3  bit2 = store enable; bits[1:0]: 00 SB, 01 SH, 10 SW.
- STALL  out  1  holds PC and all pipeline registers; combinational from state and inputs.
- LOAD_DATA  out  32  extended load result; registered.
- MISALIGN  out  1  one-cycle pulse in DONE for a rejected misaligned access.
- BUS_ERR  out  1  one-cycle pulse in DONE for a timeout abort.
- DMEM_REQ  out  1  request to memory; registered.
- DMEM_WE  out  1  1 = write, 0 = read; valid while DMEM_REQ=1.
- DMEM_ADDR  out  32  word address, {addr[31:2], 2'b00}.
- DMEM_WDATA  out  32  lane-replicated store data.
- DMEM_BE  out  4  byte enables. Stores: lane mask. Loads: 4'b1111.
- DMEM_RDATA  in  32  read word; valid when DMEM_ACK=1.
- DMEM_ACK  in  1  one-cycle completion strobe.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE**
  - Access present (load or store enable set), aligned: STALL=1. Next cycle go to WAIT with DMEM_REQ=1 and the DMEM_* fields registered.
  - Access present, misaligned: STALL=1. Go to DONE with MISALIGN=1 and no memory request.
  - No access: STALL=0.
- **WAIT**
  - STALL=1. DMEM_REQ and all DMEM_* outputs are held constant.
  - On DMEM_ACK: register LOAD_DATA (loads only), drop DMEM_REQ, go to DONE.
- **DONE**
  - STALL=0 for exactly one cycle, so the pipeline advances past the completed instruction.
  - Always go to IDLE next. The next access is therefore evaluated one cycle later, never in DONE.
- Misalignment rules:
  - LH, LHU, SH: addr[0]=1.
  - LW, SW: addr[1:0]≠00.
  - Bytes are never misaligned.
- Load and store both enabled: the load wins and the store is ignored.
- Unlisted funct3 encodings are treated as LW.
- Store lanes, with a = addr[1:0]:
  - SB: BE = 4'b0001<<a; WDATA = {4{d[7:0]}}.
  - SH: BE = 4'b0011<<a; WDATA = {2{d[15:0]}}.
  - SW: BE = 4'b1111; WDATA = d.
- Load extract, from RDATA>>(8*a):
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: pass through.
- LOAD_DATA holds its value until the next acknowledged load. Stores, misaligns and aborts leave it unchanged.
- DMEM_ACK in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; LOAD_DATA=0; DMEM_REQ=0; DMEM_WE=0; DMEM_ADDR=0; DMEM_WDATA=0; DMEM_BE=0; MISALIGN=0; BUS_ERR=0.
- STALL follows the IDLE/WAIT/DONE rules even in the reset cycle.
- Latency:
  - Access enters MEM at cycle 0 (IDLE, STALL=1).
  - DMEM_REQ rises at cycle 1.
  - ACK at cycle k≥1 gives DONE at k+1.
  - Zero-wait memory (ACK at cycle 1): the instruction occupies MEM for 3 cycles.
- Misaligned access: IDLE → DONE, 2 cycles, MISALIGN high in cycle 1.
- RESET during WAIT: DMEM_REQ drops the next edge and the transaction is abandoned. A later ACK is ignored.
- Back-to-back accesses: each pays the full IDLE→WAIT→DONE sequence; there is no overlap.

## Configuration
- DMEM_ACCESS_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering WAIT and increments every WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without ACK: drop DMEM_REQ, go to DONE with BUS_ERR=1, LOAD_DATA unchanged.
  - ACK arriving in the same cycle as expiry wins; the access completes normally.
- Not defined: no counter, and WAIT lasts until ACK. BUS_ERR is tied 0.

## Structure
- Shared package `dmem_defs`: load funct3 codes, store size codes, and state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
- One sub-module, `dmem_lane_align` (combinational): misalign check, BE and WDATA generation, and load extract/extend.
- FSM, registers and timeout counter live in the top module.

## Test plan
- LW at 0x100, ACK at cycle 1, RDATA=0xDEADBEEF → STALL=1 for cycles 0–1, 0 at cycle 2; LOAD_DATA=0xDEADBEEF.
- LB at 0x103, RDATA=0x80FFFFFF → LOAD_DATA=0xFFFFFF80. LBU at 0x103 → LOAD_DATA=0x00000080.
- SH at 0x202 with data 0x1234ABCD → DMEM_BE=4'b1100, DMEM_WDATA=0xABCDABCD, DMEM_ADDR=0x200, DMEM_WE=1.
- LW at 0x101 → no DMEM_REQ; MISALIGN pulses once; STALL=0 after 2 cycles; LOAD_DATA unchanged.
- ACK delayed 5 cycles, then RESET asserted in WAIT → DMEM_REQ=0 and state IDLE next cycle; the late ACK produces no LOAD_DATA change.
- With DMEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ACK → BUS_ERR pulses once, DMEM_REQ drops, STALL releases.
